motor_pwm_driver: RTL
=====================

Name: motor_pwm_driver

Overview:
- Downstream stage of the steering PID loop. Consumes each signed 16-bit steering correction and the 0-9 speed level.
- Produces differential left/right motor PWM with saturation, per-period slew limiting, glitch-free duty updates and a loss-of-update watchdog.
- Sits between the PID controller and the motor H-bridge pins.

Parameters:
- PWM_BITS, 10, PWM counter/duty width; period = 2^PWM_BITS clk cycles.
- BASE_STEP, 100, base duty per speed level.
- CORR_SHIFT, 2, arithmetic right shift applied to the correction before mixing.
- SLEW_STEP, 64, maximum duty change per PWM period per channel.
- WDOG_CYCLES, 5000000, clk cycles without a valid correction before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  motor enable; low forces motors off
- control_in  in  16 signed  steering correction from the PID stage
- control_valid  in  1  one-cycle strobe; control_in valid this cycle
- speed_level  in  4  base speed 0-9; values 10-15 treated as 9
- pwm_left  out  1  left motor PWM
- pwm_right  out  1  right motor PWM
- duty_left  out  PWM_BITS  currently applied left duty
- duty_right  out  PWM_BITS  currently applied right duty
- timeout  out  1  watchdog expired; high until next control_valid

Behaviour:
- Reset (rst low, async): PWM counter, both duties, both targets, pipeline regs and watchdog counter = 0. timeout = 0; pwm_left/right = 0.
- Pipeline stage 1 (cycle N, control_valid=1):
  - register corr = control_in >>> CORR_SHIFT (sign-preserving).
  - register base = min(speed_level,9) * BASE_STEP.
- Pipeline stage 2 (cycle N+1):
  - left_raw = base + corr, right_raw = base - corr, computed in 18-bit signed.
  - saturate each to [0, 2^PWM_BITS-1].
  - targets register at N+2.
- Back-to-back control_valid accepted every cycle; last one wins.
- PWM counter: free-runs 0 .. 2^PWM_BITS-1, wraps to 0.
- pwm_x = enable && (counter < duty_x). Combinational compare, registered output, so one cycle of latency to the pin.
- Duty update occurs only on the wrap cycle (counter == max), giving glitch-free update:
  - duty moves toward target by min(|target-duty|, SLEW_STEP).
  - equal target: hold.
  - a target landing on the wrap cycle itself is used at the next wrap.
- Watchdog:
  - counter reloads to 0 on control_valid; otherwise increments, saturating.
  - on reaching WDOG_CYCLES-1, timeout <= 1 and both targets <= 0. Duties then slew down to 0.
  - control_valid while timeout=1: timeout clears next cycle; new targets follow normal pipeline.
- enable low:
  - pwm outputs low next cycle; duties forced to 0 immediately.
  - targets continue updating.
  - on enable rising, duties slew up from 0 at subsequent wraps.
- Simultaneous control_valid and watchdog expiry: control_valid wins; no timeout.
- Reset asserted mid-period or mid-slew: all state clears asynchronously. After release, counter restarts from 0 and duties are 0.

Test Plan:
- Ramp: speed_level=4, control_in=0 valid once, enable=1 -> targets 400/400. duty_left/right after successive wraps: 64,128,192,256,320,384,400, then hold. pwm_left high exactly 400 of 1024 cycles once settled.
- Mixing: settled at 400/400, control_in=+400 -> corr 100, targets 500/300. Left reaches 500 in 2 wraps (464,500), right reaches 300 in 2 wraps (336,300).
- Saturation: speed_level=9, control_in=-32768 -> corr -8192. Left target clamps to 0, right target clamps to 1023. speed_level=15, control_in=0 -> targets 900/900.
- Watchdog (bench WDOG_CYCLES=3000): no control_valid after settling at 400 -> timeout high at cycle 2999, duties slew 336,272,...,0. Next control_valid -> timeout low next cycle.
- Enable and glitch: control_valid mid-period changes the target; duty_left is unchanged until the wrap cycle. enable=0 mid-period -> pwm low next cycle, duties 0.
- Reset mid-slew: assert rst low asynchronously between clk edges -> all outputs 0 immediately. After release, counter restarts at 0 and no pwm pulse occurs until a new correction arrives.

Source files
------------

// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_driver
// Description : Differential left/right motor PWM generator fed by the
//               steering PID stage. Each accepted correction is scaled,
//               mixed with a speed-level base duty and saturated to form
//               per-channel targets. Applied duties move toward their targets
//               by a bounded step, and only on the PWM wrap cycle. A watchdog
//               zeroes the targets when corrections stop arriving.
// Ports       :
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   enable         in   motor enable, low forces the motors off
//   control_in     in   signed 16-bit steering correction
//   control_valid  in   one-cycle strobe qualifying control_in
//   speed_level    in   base speed 0-9 (10-15 behave as 9)
//   pwm_left/right out  registered PWM pins
//   duty_left/right out currently applied duty per channel
//   timeout        out  watchdog expired, held until the next control_valid
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_driver #(
    parameter int PWM_BITS    = 10,
    parameter int BASE_STEP   = 100,
    parameter int CORR_SHIFT  = 2,
    parameter int SLEW_STEP   = 64,
    parameter int WDOG_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [15:0]  control_in,
    input  logic                control_valid,
    input  logic [3:0]          speed_level,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic [PWM_BITS-1:0] duty_left,
    output logic [PWM_BITS-1:0] duty_right,
    output logic                timeout
);

    localparam int c_WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_PRE  = c_WDOG_W'(WDOG_CYCLES - 2);
    localparam logic [PWM_BITS-1:0] c_SLEW      = PWM_BITS'(SLEW_STEP);
    localparam logic signed [17:0]  c_DUTY_MAX  = 18'((1 << PWM_BITS) - 1);

    // ------------------------------------------------------------------
    // Stage 1: scale the correction and look up the base duty
    // ------------------------------------------------------------------
    logic [3:0]         w_speed;
    logic signed [15:0] r_corr;
    logic [15:0]        r_base;
    logic               r_v1;

    assign w_speed = (speed_level > 4'd9) ? 4'd9 : speed_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_corr <= '0;
            r_base <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= control_valid;
            if (control_valid) begin
                r_corr <= control_in >>> CORR_SHIFT;
                r_base <= 16'(w_speed * BASE_STEP);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: differential mix in 18-bit signed, then clamp to duty range
    // ------------------------------------------------------------------
    logic signed [17:0] w_corr_x;
    logic signed [17:0] w_base_x;
    logic signed [17:0] w_raw_l;
    logic signed [17:0] w_raw_r;

    assign w_corr_x = {{2{r_corr[15]}}, r_corr};
    assign w_base_x = {2'b00, r_base};
    assign w_raw_l  = w_base_x + w_corr_x;
    assign w_raw_r  = w_base_x - w_corr_x;

    function automatic logic [PWM_BITS-1:0] f_sat(input logic signed [17:0] v);
        if (v < 18'sd0) begin
            return '0;
        end else if (v > c_DUTY_MAX) begin
            return '1;
        end else begin
            return v[PWM_BITS-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Loss-of-update watchdog
    // ------------------------------------------------------------------
    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout;
    logic                w_expire;

    // Fires once, on the cycle the idle count steps onto its last value.
    // A correction arriving the same cycle reloads the count instead.
    assign w_expire = !control_valid && (r_wdog == c_WDOG_PRE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (control_valid) begin
                r_wdog <= '0;
            end else if (r_wdog != c_WDOG_LAST) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (control_valid) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Target registers
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_tgt_l;
    logic [PWM_BITS-1:0] r_tgt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tgt_l <= '0;
            r_tgt_r <= '0;
        end else if (w_expire) begin
            r_tgt_l <= '0;
            r_tgt_r <= '0;
        end else if (r_v1) begin
            r_tgt_l <= f_sat(w_raw_l);
            r_tgt_r <= f_sat(w_raw_r);
        end
    end

    // ------------------------------------------------------------------
    // PWM counter, slew-limited duties and output pins
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty_l;
    logic [PWM_BITS-1:0] r_duty_r;
    logic                r_pwm_l;
    logic                r_pwm_r;
    logic                w_wrap;

    assign w_wrap = &r_cnt;

    function automatic logic [PWM_BITS-1:0] f_slew(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        if (tgt > cur) begin
            return ((tgt - cur) > c_SLEW) ? (cur + c_SLEW) : tgt;
        end else if (cur > tgt) begin
            return ((cur - tgt) > c_SLEW) ? (cur - c_SLEW) : tgt;
        end else begin
            return cur;
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Duties only change on the wrap cycle so a period never sees two
    // different compare values; the target sampled here is the one held
    // before this edge, so a target written on the wrap waits a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_l <= '0;
            r_duty_r <= '0;
        end else if (!enable) begin
            r_duty_l <= '0;
            r_duty_r <= '0;
        end else if (w_wrap) begin
            r_duty_l <= f_slew(r_duty_l, r_tgt_l);
            r_duty_r <= f_slew(r_duty_r, r_tgt_r);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_l <= 1'b0;
            r_pwm_r <= 1'b0;
        end else begin
            r_pwm_l <= enable && (r_cnt < r_duty_l);
            r_pwm_r <= enable && (r_cnt < r_duty_r);
        end
    end

    assign pwm_left   = r_pwm_l;
    assign pwm_right  = r_pwm_r;
    // Reported duty drops to zero in the same cycle enable falls.
    assign duty_left  = enable ? r_duty_l : '0;
    assign duty_right = enable ? r_duty_r : '0;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire
